// File: rtl/misr_compactor_if.sv
// misr_compactor_if: handshake and signature bus between the LBIST response source and the MISR
//   start      run start/restart pulse (master -> slave)
//   resp       CUT response vector (master -> slave)
//   resp_valid resp is valid this cycle (master -> slave)
//   resp_ready compactor accepts a response this cycle (slave -> master)
//   sig        current signature (slave -> master)
//   sig_valid  signature final (slave -> master)
//   busy       run in progress (slave -> master)
interface misr_compactor_if #(parameter int RC_BITS = 8);
  logic               start;
  logic [RC_BITS-1:0] resp;
  logic               resp_valid;
  logic               resp_ready;
  logic [RC_BITS-1:0] sig;
  logic               sig_valid;
  logic               busy;
  modport master (output start, resp, resp_valid, input resp_ready, sig, sig_valid, busy);
  modport slave (input start, resp, resp_valid, output resp_ready, sig, sig_valid, busy);
endinterface

// File: rtl/misr_compactor.sv
// misr_compactor: multiple-input signature register compacting NUM_PATTERNS responses into one signature
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   slave side of misr_compactor_if (start/resp/resp_valid in; resp_ready/sig/sig_valid/busy out)
module misr_compactor #(
  parameter int                 RC_BITS      = 8,
  parameter int                 NUM_PATTERNS = 16,
  parameter logic [RC_BITS-1:0] POLY         = 8'h1D,
  parameter logic [RC_BITS-1:0] SEED         = 8'h00
) (
  input logic              clk,
  input logic              rst_n,
  misr_compactor_if.slave  bus
);
  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);
  typedef enum logic [1:0] {IDLE, COMPACT, DONE} state_t;
  state_t             state;
  logic [RC_BITS-1:0] sig;
  logic [RC_BITS-1:0] nxt;
  logic [CW-1:0]      cnt;
  logic               sig_valid;
  always_comb nxt = {sig[RC_BITS-2:0], 1'b0} ^ (sig[RC_BITS-1] ? POLY : '0) ^ bus.resp;
  // start outranks resp_valid in every state, so a restart discards that cycle's response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sig       <= '0;
      cnt       <= '0;
      sig_valid <= 1'b0;
    end else if (bus.start) begin
      state     <= COMPACT;
      sig       <= SEED;
      cnt       <= '0;
      sig_valid <= 1'b0;
    end else if (state == COMPACT && bus.resp_valid) begin
      sig <= nxt;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state     <= DONE;
        sig_valid <= 1'b1;
      end
    end
  end
  assign bus.sig        = sig;
  assign bus.sig_valid  = sig_valid;
  assign bus.busy       = state == COMPACT;
  assign bus.resp_ready = state == COMPACT;
endmodule

// File: tb/tb_misr_compactor.sv
// tb_misr_compactor: directed self-checking bench for misr_compactor with NUM_PATTERNS=4
module tb_misr_compactor;
  logic clk;
  logic rst_n;
  int checks;
  int errors;
  logic [7:0] dat [4];
  logic [7:0] exp_sig [4];
  misr_compactor_if #(.RC_BITS(8)) bus ();
  misr_compactor #(.RC_BITS(8), .NUM_PATTERNS(4), .POLY(8'h1D), .SEED(8'h00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic cyc(input logic s, input logic v, input logic [7:0] r);
    bus.start = s;
    bus.resp_valid = v;
    bus.resp = r;
    @(negedge clk);
    bus.start = 0;
    bus.resp_valid = 0;
  endtask
  task automatic test_reset;
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'hFC);
    checks++;
    if (bus.sig !== 8'hFC) begin errors++; $display("FAIL reset_pre sig got %h want fc", bus.sig); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus.sig !== 8'h00) begin errors++; $display("FAIL reset_sig got %h want 00", bus.sig); end
    checks++;
    if (bus.sig_valid !== 1'b0 || bus.busy !== 1'b0 || bus.resp_ready !== 1'b0) begin
      errors++; $display("FAIL reset_flags got v%b b%b r%b want 000", bus.sig_valid, bus.busy, bus.resp_ready);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_basic;
    cyc(1, 0, 8'h00);
    checks++;
    if (bus.busy !== 1'b1 || bus.resp_ready !== 1'b1 || bus.sig !== 8'h00 || bus.sig_valid !== 1'b0) begin
      errors++; $display("FAIL basic_start got b%b r%b s%h v%b want 1 1 00 0", bus.busy, bus.resp_ready, bus.sig, bus.sig_valid);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, dat[i]);
      checks++;
      if (bus.sig !== exp_sig[i] || bus.sig_valid !== (i == 3)) begin
        errors++; $display("FAIL basic_step%0d got %h v%b want %h v%b", i, bus.sig, bus.sig_valid, exp_sig[i], i == 3);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_ready !== 1'b0) begin
      errors++; $display("FAIL basic_done got b%b r%b want 0 0", bus.busy, bus.resp_ready);
    end
  endtask
  task automatic test_gaps;
    int gap [4] = '{1, 3, 2, 1};
    logic [7:0] prev;
    cyc(1, 0, 8'h00);
    prev = 8'h00;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        cyc(0, 0, 8'hAA);
        checks++;
        if (bus.sig !== prev || bus.busy !== 1'b1 || bus.sig_valid !== 1'b0) begin
          errors++; $display("FAIL gap%0d_%0d got %h b%b v%b want %h b1 v0", i, g, bus.sig, bus.busy, bus.sig_valid, prev);
        end
      end
      cyc(0, 1, dat[i]);
      prev = exp_sig[i];
      checks++;
      if (bus.sig !== exp_sig[i]) begin errors++; $display("FAIL gap_step%0d got %h want %h", i, bus.sig, exp_sig[i]); end
    end
    checks++;
    if (bus.sig_valid !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL gap_done got v%b b%b want 1 0", bus.sig_valid, bus.busy);
    end
  endtask
  task automatic test_zero;
    cyc(1, 0, 8'h00);
    checks++;
    if (bus.sig_valid !== 1'b0) begin errors++; $display("FAIL zero_clear got v%b want 0", bus.sig_valid); end
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00);
    checks++;
    if (bus.sig !== 8'h00 || bus.sig_valid !== 1'b1) begin
      errors++; $display("FAIL zero_sig got %h v%b want golden 00 v1", bus.sig, bus.sig_valid);
    end
  endtask
  task automatic test_restart;
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'hFC);
    cyc(0, 1, 8'h00);
    checks++;
    if (bus.sig !== 8'hE5) begin errors++; $display("FAIL restart_mid got %h want e5", bus.sig); end
    cyc(1, 1, 8'hFC);
    checks++;
    if (bus.sig !== 8'h00 || bus.busy !== 1'b1 || bus.sig_valid !== 1'b0) begin
      errors++; $display("FAIL restart_seed got %h b%b v%b want 00 1 0", bus.sig, bus.busy, bus.sig_valid);
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, dat[i]);
    checks++;
    if (bus.sig !== 8'hB3 || bus.sig_valid !== 1'b1) begin
      errors++; $display("FAIL restart_final got %h v%b want b3 1", bus.sig, bus.sig_valid);
    end
    cyc(0, 1, 8'hFC);
    cyc(0, 1, 8'h5A);
    checks++;
    if (bus.sig !== 8'hB3 || bus.sig_valid !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL done_frozen got %h v%b b%b want b3 1 0", bus.sig, bus.sig_valid, bus.busy);
    end
  endtask
  task automatic test_reset_midrun;
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 1, dat[i]);
    checks++;
    if (bus.sig !== 8'hD7) begin errors++; $display("FAIL midrun_pre got %h want d7", bus.sig); end
    rst_n = 0;
    #1;
    checks++;
    if (bus.sig !== 8'h00 || bus.sig_valid !== 1'b0 || bus.busy !== 1'b0 || bus.resp_ready !== 1'b0) begin
      errors++; $display("FAIL midrun_rst got %h v%b b%b r%b want 00 000", bus.sig, bus.sig_valid, bus.busy, bus.resp_ready);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    cyc(1, 1, 8'hFC);
    checks++;
    if (bus.sig !== 8'h00 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL idle_start_resp got %h b%b want 00 1", bus.sig, bus.busy);
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, dat[i]);
    checks++;
    if (bus.sig !== 8'hB3 || bus.sig_valid !== 1'b1) begin
      errors++; $display("FAIL midrun_final got %h v%b want b3 1", bus.sig, bus.sig_valid);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    dat = '{8'hFC, 8'h00, 8'h00, 8'h00};
    exp_sig = '{8'hFC, 8'hE5, 8'hD7, 8'hB3};
    rst_n = 0;
    bus.start = 0;
    bus.resp_valid = 0;
    bus.resp = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_gaps;
    test_zero;
    test_restart;
    test_reset_midrun;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
